// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and the
// iteration count.
package mips_pkg;

    typedef logic [1:0] muldiv_op_t;

    localparam muldiv_op_t MULDIV_MULT  = 2'b00;
    localparam muldiv_op_t MULDIV_MULTU = 2'b01;
    localparam muldiv_op_t MULDIV_DIV   = 2'b10;
    localparam muldiv_op_t MULDIV_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int MULDIV_ITERS = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_ITERS);
    localparam logic [MULDIV_CNT_W-1:0] MULDIV_LAST = MULDIV_CNT_W'(MULDIV_ITERS - 1);

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation; used both for operand absolute values
// and for applying the result sign to products, quotients and remainders.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? -value : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit holding the MIPS HI/LO registers.
// The divider datapath is only built when MULDIV_DIV_EN is defined.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] read_data_1,
    input  logic [WIDTH-1:0] read_data_2,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]              state;
    logic [MULDIV_CNT_W-1:0] count;
    logic [2*WIDTH-1:0]      acc;   // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]        opnd;  // multiplicand or divisor magnitude
    logic                    neg_res;

    logic is_signed, is_div, idle_or_done, accept, last;
    logic [WIDTH-1:0] abs_rs, abs_rt;

    assign is_signed    = ~op[0];
    assign is_div       = op[1];
    assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
    assign accept       = start && idle_or_done;
    assign last         = (count == '0);

    assign busy = (state == ST_MUL) || (state == ST_DIV);
    assign done = (state == ST_DONE);

    muldiv_sign_fix #(.W(WIDTH)) u_abs_rs (
        .value  (read_data_1),
        .negate (is_signed & read_data_1[WIDTH-1]),
        .result (abs_rs)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_abs_rt (
        .value  (read_data_2),
        .negate (is_signed & read_data_2[WIDTH-1]),
        .result (abs_rt)
    );

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, prod_res;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .value  (mul_next),
        .negate (neg_res),
        .result (prod_res)
    );

`ifdef MULDIV_DIV_EN
    logic                neg_rem;
    logic [WIDTH:0]      div_shift, div_diff;
    logic                div_ge;
    logic [2*WIDTH-1:0]  div_next;
    logic [WIDTH-1:0]    quo_res, rem_res;

    // Restoring step: shift in the next dividend bit, keep the difference only
    // when it did not go negative.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};

    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
        .value  (div_next[WIDTH-1:0]),
        .negate (neg_res),
        .result (quo_res)
    );

    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
        .value  (div_next[2*WIDTH-1:WIDTH]),
        .negate (neg_rem),
        .result (rem_res)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            count       <= '0;
            acc         <= '0;
            opnd        <= '0;
            neg_res     <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem     <= 1'b0;
`endif
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
                        count       <= MULDIV_LAST;
                        neg_res     <= is_signed & (read_data_1[WIDTH-1] ^ read_data_2[WIDTH-1]);
                        if (!is_div) begin
                            state <= ST_MUL;
                            acc   <= {{WIDTH{1'b0}}, abs_rt};
                            opnd  <= abs_rs;
                        end else begin
`ifdef MULDIV_DIV_EN
                            neg_rem <= is_signed & read_data_1[WIDTH-1];
                            if (read_data_2 == '0) begin
                                state       <= ST_DONE;
                                div_by_zero <= 1'b1;
                            end else begin
                                state <= ST_DIV;
                                acc   <= {{WIDTH{1'b0}}, abs_rs};
                                opnd  <= abs_rt;
                            end
`else
                            state <= ST_DONE;
`endif
                        end
                    end else begin
                        state <= ST_IDLE;
                        if (hi_we) hi <= read_data_1;
                        if (lo_we) lo <= read_data_1;
                    end
                end
                ST_MUL: begin
                    acc   <= mul_next;
                    count <= count - MULDIV_CNT_W'(1);
                    if (last) begin
                        state <= ST_DONE;
                        hi    <= prod_res[2*WIDTH-1:WIDTH];
                        lo    <= prod_res[WIDTH-1:0];
                    end
                end
`ifdef MULDIV_DIV_EN
                ST_DIV: begin
                    acc   <= div_next;
                    count <= count - MULDIV_CNT_W'(1);
                    if (last) begin
                        state <= ST_DONE;
                        hi    <= rem_res;
                        lo    <= quo_res;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the MIPS execute stage, operating beside the ALU on the same rs/rt operands. It implements mult, multu, div and divu over 32 cycles and holds the HI/LO architectural registers. The hi/lo outputs feed the execute-stage result mux for mfhi/mflo. A start/busy/done handshake lets the hazard unit stall the pipeline while an operation is in flight.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  requests an operation; sampled on the rising edge.
- op  input  2  operation: 00 mult, 01 multu, 10 div, 11 divu.
- read_data_1  input  32  rs: multiplicand or dividend.
- read_data_2  input  32  rt: multiplier or divisor.
- hi_we, lo_we  input  1 each  mthi/mtlo write enables; data comes from read_data_1.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle.
- div_by_zero  output  1  valid with done; set for a div/divu with rt==0.
- hi, lo  output  32 each  architectural HI/LO registers.

## Operation
- States:
  - IDLE: waiting for work.
  - MUL: 32 multiply iterations.
  - DIV: 32 divide iterations.
  - DONE: result presented.
- Acceptance:
  - start is accepted only in IDLE or DONE.
  - start in MUL or DIV is ignored; no error is flagged.
- On accept, the unit latches the operand magnitudes, result-sign flags and op, and loads the iteration counter with 31.
- Signed ops take absolute values of the operands; unsigned ops use them raw.
- Multiply:
  - Shift-add, one multiplier bit per cycle, into a 64-bit product.
  - If the result sign is negative, the unit negates the 64-bit product.
  - Writes HI = product[63:32], LO = product[31:0].
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Quotient sign = sign(rs) XOR sign(rt). Remainder sign = sign(rs).
  - Writes LO = quotient, HI = remainder.
- Divide by zero:
  - No iterations; the unit goes straight to DONE.
  - HI/LO are left unchanged and div_by_zero = 1.
- Signed overflow (0x80000000 / 0xFFFFFFFF) gives LO = 0x80000000, HI = 0. This is the natural modulo-2^32 result; no special case.
- mthi/mtlo:
  - hi_we/lo_we write HI/LO on the edge when state is IDLE or DONE and start = 0.
  - While busy, or in the same cycle as an accepted start, the writes are discarded.
- Unused op combinations: none; all 4 encodings are legal.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - hi = lo = 0; busy = done = div_by_zero = 0.
- Reset mid-operation aborts: the unit returns to IDLE, HI/LO are cleared, and no done is issued.
- Latency, with start accepted in cycle 0:
  - Multiply or divide:
    - Cycles 1–32: MUL/DIV, busy = 1.
    - Cycle 33: DONE, done = 1, busy = 0, hi/lo updated on the edge entering cycle 33.
  - Divide by zero: DONE in cycle 1, busy never asserted.
- DONE lasts one cycle, then the unit returns to IDLE.
- A start in DONE goes directly to MUL/DIV, giving back-to-back throughput of one operation per 33 cycles.
- hi/lo are registered outputs. They are stable except on result edges and accepted mthi/mtlo edges.
- div_by_zero is cleared on every accepted start.

## Configuration
- Macro: MULDIV_DIV_EN.
- Defined: the full divider is present as described.
- Undefined:
  - No divider datapath is generated.
  - div/divu go to DONE in cycle 1 with HI/LO unchanged and div_by_zero = 0.
  - mult/multu are unaffected.

## Structure
- The shared package mips_pkg holds:
  - op encodings MULDIV_MULT, MULDIV_MULTU, MULDIV_DIV, MULDIV_DIVU;
  - the state encoding (IDLE, MUL, DIV, DONE);
  - the iteration count constant 32.
- Sub-module muldiv_sign_fix is combinational and shared by the input and output paths. It computes the absolute value when signed, and conditionally negates 32-bit and 64-bit values.
- The FSM, counter, HI/LO registers and the two iteration datapaths live in muldiv_unit.

## Test plan
- mult 0xFFFFFFFF × 0x00000002 -> cycle 33: done = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFFE; busy high in cycles 1–32.
- multu 0xFFFFFFFF × 0x00000002 -> HI = 0x00000001, LO = 0xFFFFFFFE.
- div 0xFFFFFFF9 (−7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- divu 7 / 2 -> LO = 3, HI = 1.
- mthi 0x1234, mtlo 0x5678, then div 5 / 0 -> cycle 1: done = 1, div_by_zero = 1, HI = 0x1234, LO = 0x5678 (macro defined).
- div 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- start multu in cycle 0, second start plus hi_we in cycle 5, reset in cycle 10:
  - Cycles 5–9: second start and hi_we are ignored.
  - From cycle 10: busy = 0, HI = LO = 0, no done pulse.
